// File: rtl/arp_pair_fifo.sv
// arp_pair_fifo: single-clock FIFO buffering learned {IPv4, MAC} pairs between ARP rx and the table FSM.
module arp_pair_fifo #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0] wp, rp;
    logic do_read, do_write;
    assign empty = wp == rp;
    assign full = (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]) && (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0]);
    assign count = wp - rp;
    assign do_read = read && !empty;
    // a concurrent pop frees a slot, so a push while full is still accepted
    assign do_write = write && (!full || do_read);
    always_ff @(posedge clk)
        if (!rst && do_write) mem[wp[ADDR_WIDTH-1:0]] <= data_in;
    always_ff @(posedge clk)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            data_out <= '0;
        end else begin
            if (do_write) wp <= wp + 1'b1;
            if (do_read) begin
                data_out <= mem[rp[ADDR_WIDTH-1:0]];
                rp <= rp + 1'b1;
            end
        end
endmodule

// File: tb/tb_arp_pair_fifo.sv
// tb_arp_pair_fifo: directed vectors with hand-computed expectations for arp_pair_fifo.
module tb_arp_pair_fifo;
    localparam int AW = 2;
    localparam int DW = 80;
    logic clk = 0, rst = 1, write = 0, read = 0;
    logic [DW-1:0] data_in = '0, data_out;
    logic empty, full;
    logic [AW:0] count;
    int n_vec = 0, n_bad = 0;

    arp_pair_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .write(write), .data_in(data_in), .read(read),
        .data_out(data_out), .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        write = 1;
        data_in = d;
        tick;
        write = 0;
    endtask

    task automatic pop;
        read = 1;
        tick;
        read = 0;
    endtask

    function automatic logic [DW-1:0] w(input int i);
        return {32'h0A000000 + 32'(i), 48'hAABBCC000000 + 48'(i)};
    endfunction

    localparam logic [DW-1:0] P1 = {32'hC0A80001, 48'h112233445566};
    localparam logic [DW-1:0] A = {32'hC0A80002, 48'h0000000000A1};
    localparam logic [DW-1:0] B = {32'hC0A80003, 48'h0000000000B2};
    localparam logic [DW-1:0] C = {32'hC0A80004, 48'h0000000000C3};
    localparam logic [DW-1:0] D = {32'hC0A80005, 48'h0000000000D4};
    localparam logic [DW-1:0] E = {32'hC0A80006, 48'h0000000000E5};
    localparam logic [DW-1:0] F = {32'hC0A80007, 48'h0000000000F6};
    localparam logic [DW-1:0] N = {32'h0A0A0A0A, 48'h0102030405FF};

    initial begin
        tick;
        tick;
        rst = 0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_dout", data_out, 0);
        pop;
        chk("idle_pop_dout", data_out, 0);
        chk("idle_pop_count", count, 0);
        chk("idle_pop_empty", empty, 1);

        push(P1);
        chk("p1_empty", empty, 0);
        chk("p1_count", count, 1);
        pop;
        chk("p1_dout", data_out, P1);
        chk("p1_drained", empty, 1);

        push(A); push(B); push(C); push(D);
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        push(E);
        chk("drop_count", count, 4);
        chk("drop_full", full, 1);
        pop; chk("pop_a", data_out, A);
        pop; chk("pop_b", data_out, B);
        pop; chk("pop_c", data_out, C);
        pop; chk("pop_d", data_out, D);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        push(A); push(B); push(C); push(D);
        write = 1; read = 1; data_in = F;
        tick;
        write = 0; read = 0;
        chk("full_rw_dout", data_out, A);
        chk("full_rw_count", count, 4);
        chk("full_rw_full", full, 1);
        pop; chk("pop2_b", data_out, B);
        pop; chk("pop2_c", data_out, C);
        pop; chk("pop2_d", data_out, D);
        pop; chk("pop2_f", data_out, F);
        chk("drain2_empty", empty, 1);

        write = 1; read = 1; data_in = w(0);
        tick;
        chk("empty_rw_dout", data_out, F);
        chk("empty_rw_count", count, 1);
        for (int i = 0; i < 10; i++) begin
            write = (i < 9);
            data_in = w(i + 1);
            read = 1;
            tick;
            chk($sformatf("wrap_dout%0d", i), data_out, w(i));
            chk($sformatf("wrap_count%0d", i), count, (i < 9) ? 1 : 0);
            chk($sformatf("wrap_full%0d", i), full, 0);
        end
        write = 0; read = 0;
        chk("wrap_empty", empty, 1);

        push(A); push(B); push(C);
        chk("pre_rst_count", count, 3);
        rst = 1; write = 1; data_in = E;
        tick;
        rst = 0; write = 0;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_dout", data_out, 0);
        push(N);
        pop;
        chk("post_rst_dout", data_out, N);
        chk("post_rst_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
